// File: rtl/axi_split_read_engine.sv
// axi_split_read_engine
// Splits one linear read command into AXI4 INCR bursts. Each burst is capped
// at MAX_BURST beats and never crosses a 4 KB page. Up to MAX_OUTSTANDING AR
// requests are kept in flight. R data streams straight through to the user.
// Optional: define AXI_SPLIT_RD_STATS_EN to add the stat_cycles/stat_stall
// counters and ports.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// ISSUE | issuing AR bursts until every beat has been requested
// DRAIN | all ARs issued; waiting for the final R beat
module axi_split_read_engine #(
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 6,
  parameter int LEN_WIDTH       = 8,
  parameter int ENGINE_ID       = 0,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_beats,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
`ifdef AXI_SPLIT_RD_STATS_EN
  output logic [31:0]           stat_cycles,
  output logic [31:0]           stat_stall,
`endif
  output logic                  m_axi_ARVALID,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  output logic [LEN_WIDTH-1:0]  m_axi_ARLEN,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  input  logic                  m_axi_ARREADY,
  input  logic                  m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic                  m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  input  logic [1:0]            m_axi_RRESP,
  output logic                  m_axi_RREADY
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BLEN_W = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  issue_rem_q;
  logic [CNT_WIDTH-1:0]  recv_rem_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [LEN_WIDTH-1:0]  arlen_q;
  logic                  done_q;
  logic                  err_q;

  logic                  cmd_fire;
  logic                  ar_fire;
  logic                  beat_fire;
  logic                  last_fire;
  logic                  final_beat;
  logic                  can_issue;
  logic [12:0]           bound_bytes;
  logic [12:0]           bound_beats;
  logic [CNT_WIDTH-1:0]  len_c;
  logic [BLEN_W-1:0]     cur_len;
  logic                  unused_rid;

  assign cmd_ready     = (state_q == IDLE);
  assign cmd_fire      = cmd_valid & cmd_ready;
  assign ar_fire       = arvalid_q & m_axi_ARREADY;
  assign beat_fire     = m_axi_RVALID & rd_ready;
  assign last_fire     = beat_fire & m_axi_RLAST;
  assign final_beat    = beat_fire & (recv_rem_q == CNT_WIDTH'(1)) & (state_q != IDLE);
  assign cur_len       = BLEN_W'(arlen_q) + BLEN_W'(1);
  assign can_issue     = (state_q == ISSUE) & ~arvalid_q & (issue_rem_q != '0) &
                         (outstanding_q < OUT_W'(MAX_OUTSTANDING));

  // Beats left before the next 4 KB page boundary.
  assign bound_bytes   = 13'd4096 - {1'b0, addr_q[11:0]};
  assign bound_beats   = bound_bytes >> BSHIFT;

  assign rd_data       = m_axi_RDATA;
  assign rd_valid      = m_axi_RVALID;
  assign m_axi_RREADY  = rd_ready;
  assign rd_last       = m_axi_RVALID & (recv_rem_q == CNT_WIDTH'(1));
  assign done          = done_q;
  assign err           = err_q;

  assign m_axi_ARVALID = arvalid_q;
  assign m_axi_ARADDR  = araddr_q;
  assign m_axi_ARLEN   = arlen_q;
  assign m_axi_ARID    = ID_WIDTH'(ENGINE_ID);
  assign m_axi_ARSIZE  = 3'(BSHIFT);
  assign m_axi_ARBURST = 2'b01;

  // Responses are in order on a single ID, so RID carries no information.
  assign unused_rid    = ^m_axi_RID;

  // Next burst length: min(remaining, MAX_BURST, beats to page end).
  always_comb begin
    len_c = issue_rem_q;
    if (len_c > CNT_WIDTH'(MAX_BURST))   len_c = CNT_WIDTH'(MAX_BURST);
    if (len_c > CNT_WIDTH'(bound_beats)) len_c = CNT_WIDTH'(bound_beats);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire && cmd_beats != '0) state_d = ISSUE;
      ISSUE:   if (ar_fire && issue_rem_q == CNT_WIDTH'(cur_len)) state_d = DRAIN;
      DRAIN:   if (final_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AR issue path: address/remaining bookkeeping and the registered AR beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= '0;
      issue_rem_q <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q      <= cmd_addr;
        issue_rem_q <= cmd_beats;
      end else if (ar_fire) begin
        addr_q      <= addr_q + (ADDR_WIDTH'(cur_len) << BSHIFT);
        issue_rem_q <= issue_rem_q - CNT_WIDTH'(cur_len);
      end
      if (ar_fire) begin
        arvalid_q <= 1'b0;
      end else if (can_issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_q;
        arlen_q   <= LEN_WIDTH'(len_c - CNT_WIDTH'(1));
      end
    end
  end

  // Outstanding burst count; a simultaneous issue and retire cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding_q <= '0;
    end else begin
      case ({ar_fire, last_fire && outstanding_q != '0})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Receive count, completion pulse and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      recv_rem_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (cmd_fire)                            recv_rem_q <= cmd_beats;
      else if (beat_fire && recv_rem_q != '0)  recv_rem_q <= recv_rem_q - CNT_WIDTH'(1);
      done_q <= (cmd_fire && cmd_beats == '0) || final_beat;
      if (cmd_fire)                            err_q <= 1'b0;
      else if (beat_fire && m_axi_RRESP != 2'b00) err_q <= 1'b1;
    end
  end

`ifdef AXI_SPLIT_RD_STATS_EN
  logic stat_active_q;

  // Per-command cycle and stall counters, saturating, frozen after done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_active_q <= 1'b0;
      stat_cycles   <= '0;
      stat_stall    <= '0;
    end else if (cmd_fire) begin
      stat_active_q <= 1'b1;
      stat_cycles   <= 32'd1;
      stat_stall    <= '0;
    end else if (stat_active_q) begin
      if (stat_cycles != '1) stat_cycles <= stat_cycles + 32'd1;
      if (m_axi_RVALID && !rd_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      if (done_q) stat_active_q <= 1'b0;
    end
  end
`endif

endmodule
